// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   state_t      : sequencer states (RUN, MEM_WAIT)
//   ctrl_t       : per-stage write-enable / flush / bubble control bundle
//   CTRL_NORMAL  : all stages advance, no flush, no bubble
//   CTRL_FREEZE  : hold every stage, inject a bubble into MEM/WB
//   CNT_W_DEF    : default performance-counter width
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_bubble;
        logic ex_mem_write;
        logic mem_wb_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_NORMAL = '{
        pc_write:      1'b1,
        if_id_write:   1'b1,
        if_id_flush:   1'b0,
        id_ex_write:   1'b1,
        id_ex_bubble:  1'b0,
        ex_mem_write:  1'b1,
        mem_wb_bubble: 1'b0
    };

    localparam ctrl_t CTRL_FREEZE = '{
        pc_write:      1'b0,
        if_id_write:   1'b0,
        if_id_flush:   1'b0,
        id_ex_write:   1'b0,
        id_ex_bubble:  1'b0,
        ex_mem_write:  1'b0,
        mem_wb_bubble: 1'b1
    };

    localparam int unsigned CNT_W_DEF = 32;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
//   clk_i : clock
//   rst_i : asynchronous active-high reset, clears the count
//   inc_i : increment request for this cycle
//   cnt_o : current count, sticks at all ones
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage MIPS pipeline.
// Merges load-use, taken-branch and multi-cycle data-memory requests into
// per-stage controls, sequences fixed-latency memory waits and keeps
// saturating stall/flush performance counters.
//   clk_i, rst_i                 : clock, asynchronous active-high reset
//   load_use_i                   : load-use hazard detected in ID
//   branch_taken_i               : branch/jump in ID resolved taken
//   dmem_req_i                   : instruction in MEM accesses data memory
//   pc_write_o .. mem_wb_bubble_o: per-stage controls (combinational)
//   mem_busy_o                   : high while in MEM_WAIT
//   stall_cnt_o / flush_cnt_o    : saturating performance counters
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LAT = 3,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_use_i,
    input  logic             branch_taken_i,
    input  logic             dmem_req_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_write_o,
    output logic             id_ex_bubble_o,
    output logic             ex_mem_write_o,
    output logic             mem_wb_bubble_o,
    output logic             mem_busy_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // MEM_LAT=1 means memory never stalls; the trigger is then constant 0.
    localparam bit         MEM_STALL = (MEM_LAT > 1);
    localparam logic [3:0] WLOAD     = MEM_STALL ? 4'(MEM_LAT - 2) : 4'd0;

    state_t     state;
    logic [3:0] wcnt;
    ctrl_t      ctrl;
    logic       start_wait;

    always_comb begin
        ctrl       = CTRL_NORMAL;
        start_wait = 1'b0;
        if (state == RUN && dmem_req_i && MEM_STALL) begin
            // Hazard/branch inputs are ignored: the frozen stages re-present them.
            ctrl       = CTRL_FREEZE;
            start_wait = 1'b1;
        end else if (state == MEM_WAIT && wcnt != 4'd0) begin
            ctrl = CTRL_FREEZE;
        end else if (load_use_i) begin
            // Branch flush is suppressed; the branch re-evaluates after the bubble.
            ctrl.pc_write     = 1'b0;
            ctrl.if_id_write  = 1'b0;
            ctrl.id_ex_bubble = 1'b1;
        end else if (branch_taken_i) begin
            ctrl.if_id_flush  = 1'b1;
        end
    end

    // The release cycle (MEM_WAIT, wcnt=0) always returns to RUN, so the
    // access just completed cannot retrigger even with dmem_req_i still high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= RUN;
            wcnt  <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (start_wait) begin
                        state <= MEM_WAIT;
                        wcnt  <= WLOAD;
                    end
                end
                MEM_WAIT: begin
                    if (wcnt != 4'd0) begin
                        wcnt <= wcnt - 4'd1;
                    end else begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                    wcnt  <= '0;
                end
            endcase
        end
    end

    assign pc_write_o      = ctrl.pc_write;
    assign if_id_write_o   = ctrl.if_id_write;
    assign if_id_flush_o   = ctrl.if_id_flush;
    assign id_ex_write_o   = ctrl.id_ex_write;
    assign id_ex_bubble_o  = ctrl.id_ex_bubble;
    assign ex_mem_write_o  = ctrl.ex_mem_write;
    assign mem_wb_bubble_o = ctrl.mem_wb_bubble;
    assign mem_busy_o      = (state == MEM_WAIT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (~ctrl.pc_write),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (ctrl.if_id_flush),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: three instances share one stimulus
// set (MEM_LAT=3/CNT_W=32, MEM_LAT=1/CNT_W=32, MEM_LAT=3/CNT_W=4).
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load_use = 1'b0;
    logic branch = 1'b0;
    logic dmem = 1'b0;

    always #5 clk = ~clk;

    logic        a_pcw, a_ifw, a_iff, a_idw, a_idb, a_exw, a_mwb, a_busy;
    logic [31:0] a_stall, a_flush;
    logic        b_pcw, b_ifw, b_iff, b_idw, b_idb, b_exw, b_mwb, b_busy;
    logic [31:0] b_stall, b_flush;
    logic        c_pcw, c_ifw, c_iff, c_idw, c_idb, c_exw, c_mwb, c_busy;
    logic [3:0]  c_stall, c_flush;

    pipeline_stall_ctrl #(.MEM_LAT(3), .CNT_W(32)) u_dut (
        .clk_i(clk), .rst_i(rst), .load_use_i(load_use), .branch_taken_i(branch),
        .dmem_req_i(dmem), .pc_write_o(a_pcw), .if_id_write_o(a_ifw),
        .if_id_flush_o(a_iff), .id_ex_write_o(a_idw), .id_ex_bubble_o(a_idb),
        .ex_mem_write_o(a_exw), .mem_wb_bubble_o(a_mwb), .mem_busy_o(a_busy),
        .stall_cnt_o(a_stall), .flush_cnt_o(a_flush)
    );

    pipeline_stall_ctrl #(.MEM_LAT(1), .CNT_W(32)) u_lat1 (
        .clk_i(clk), .rst_i(rst), .load_use_i(load_use), .branch_taken_i(branch),
        .dmem_req_i(dmem), .pc_write_o(b_pcw), .if_id_write_o(b_ifw),
        .if_id_flush_o(b_iff), .id_ex_write_o(b_idw), .id_ex_bubble_o(b_idb),
        .ex_mem_write_o(b_exw), .mem_wb_bubble_o(b_mwb), .mem_busy_o(b_busy),
        .stall_cnt_o(b_stall), .flush_cnt_o(b_flush)
    );

    pipeline_stall_ctrl #(.MEM_LAT(3), .CNT_W(4)) u_sat (
        .clk_i(clk), .rst_i(rst), .load_use_i(load_use), .branch_taken_i(branch),
        .dmem_req_i(dmem), .pc_write_o(c_pcw), .if_id_write_o(c_ifw),
        .if_id_flush_o(c_iff), .id_ex_write_o(c_idw), .id_ex_bubble_o(c_idb),
        .ex_mem_write_o(c_exw), .mem_wb_bubble_o(c_mwb), .mem_busy_o(c_busy),
        .stall_cnt_o(c_stall), .flush_cnt_o(c_flush)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        load_use = 1'b0;
        branch   = 1'b0;
        dmem     = 1'b0;
        rst      = 1'b1;
        step();
        rst      = 1'b0;
        #1;
    endtask

    // Word: {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
    //        ex_mem_write, mem_wb_bubble, mem_busy}
    function automatic logic [7:0] ctl_a();
        return {a_pcw, a_ifw, a_iff, a_idw, a_idb, a_exw, a_mwb, a_busy};
    endfunction

    function automatic logic [7:0] ctl_b();
        return {b_pcw, b_ifw, b_iff, b_idw, b_idb, b_exw, b_mwb, b_busy};
    endfunction

    localparam logic [7:0] NORMAL  = 8'b1101_0100;
    localparam logic [7:0] FRZ_RUN = 8'b0000_0010;  // freeze, still in RUN
    localparam logic [7:0] FRZ_W   = 8'b0000_0011;  // freeze, in MEM_WAIT
    localparam logic [7:0] LU      = 8'b0001_1100;
    localparam logic [7:0] BR      = 8'b1111_0100;

    initial begin : main
        logic [7:0] exp_pat [6];

        // Reset state
        do_reset();
        check("reset_ctl", 32'(ctl_a()), 32'(NORMAL));
        check("reset_stall", a_stall, 0);
        check("reset_flush", a_flush, 0);

        // Load-use alone
        load_use = 1'b1;
        #1 check("lu_ctl", 32'(ctl_a()), 32'(LU));
        step();
        load_use = 1'b0;
        #1 check("lu_stall_cnt", a_stall, 1);
        check("lu_after_ctl", 32'(ctl_a()), 32'(NORMAL));

        // Branch alone
        do_reset();
        branch = 1'b1;
        #1 check("br_ctl", 32'(ctl_a()), 32'(BR));
        step();
        branch = 1'b0;
        #1 check("br_flush_cnt", a_flush, 1);
        check("br_stall_cnt", a_stall, 0);

        // Load-use and branch together: bubble wins, no flush
        do_reset();
        load_use = 1'b1;
        branch   = 1'b1;
        #1 check("lubr_ctl", 32'(ctl_a()), 32'(LU));
        step();
        load_use = 1'b0;
        branch   = 1'b0;
        #1 check("lubr_flush_cnt", a_flush, 0);
        check("lubr_stall_cnt", a_stall, 1);

        // Single memory access, dmem held 3 cycles
        do_reset();
        dmem = 1'b1;
        exp_pat[0] = FRZ_RUN;
        exp_pat[1] = FRZ_W;
        exp_pat[2] = NORMAL | 8'b0000_0001;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("mem1_ctl_c%0d", i), 32'(ctl_a()), 32'(exp_pat[i]));
            check($sformatf("lat1_ctl_c%0d", i), 32'(ctl_b()), 32'(NORMAL));
            step();
        end
        dmem = 1'b0;
        #1 check("mem1_stall_cnt", a_stall, 2);
        check("mem1_idle_ctl", 32'(ctl_a()), 32'(NORMAL));
        check("lat1_stall_cnt", b_stall, 0);

        // Back-to-back memory accesses
        do_reset();
        dmem = 1'b1;
        exp_pat[3] = FRZ_RUN;
        exp_pat[4] = FRZ_W;
        exp_pat[5] = NORMAL | 8'b0000_0001;
        for (int i = 0; i < 6; i++) begin
            #1 check($sformatf("b2b_ctl_c%0d", i), 32'(ctl_a()), 32'(exp_pat[i]));
            step();
        end
        dmem = 1'b0;
        #1 check("b2b_stall_cnt", a_stall, 4);

        // Load-use in the release cycle is honoured; access does not retrigger
        do_reset();
        dmem = 1'b1;
        step();
        step();
        load_use = 1'b1;
        #1 check("rel_lu_ctl", 32'(ctl_a()), 32'(LU | 8'b0000_0001));
        step();
        load_use = 1'b0;
        dmem     = 1'b0;
        #1 check("rel_after_ctl", 32'(ctl_a()), 32'(NORMAL));
        check("rel_stall_cnt", a_stall, 3);

        // Asynchronous reset in the middle of a wait
        do_reset();
        dmem = 1'b1;
        step();
        #1 check("midwait_busy", 32'(a_busy), 1);
        dmem = 1'b0;
        #1 rst = 1'b1;
        #1 check("midwait_rst_ctl", 32'(ctl_a()), 32'(NORMAL));
        check("midwait_rst_stall", a_stall, 0);
        step();
        rst = 1'b0;
        #1 check("midwait_post_ctl", 32'(ctl_a()), 32'(NORMAL));

        // Saturation on a 4-bit counter
        do_reset();
        load_use = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 14) check("sat_at_15", 32'(c_stall), 15);
        end
        load_use = 1'b0;
        #1 check("sat_held_15", 32'(c_stall), 15);
        check("wide_stall_20", a_stall, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Merges three requests into one consistent set of per-stage write-enable, flush and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB:
  - load-use bubble request from hazard detection;
  - taken-branch flush from ID;
  - multi-cycle data-memory access in MEM.
- Sequences fixed-latency memory waits with an internal down-counter.
- Keeps saturating stall and flush performance counters.

Parameters:
MEM_LAT, 3, data-memory access latency in cycles (legal 1..16); 1 means no memory stall.
CNT_W, 32, width of the performance counters.

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rst_i  input  1  asynchronous active-high reset.
load_use_i  input  1  load-use hazard in ID (MemRead in EX and rt matches an ID source).
branch_taken_i  input  1  branch/jump in ID resolved taken.
dmem_req_i  input  1  instruction in MEM reads or writes data memory.
pc_write_o  output  1  PC load enable.
if_id_write_o  output  1  IF/ID register load enable.
if_id_flush_o  output  1  zero IF/ID on the next edge.
id_ex_write_o  output  1  ID/EX register load enable.
id_ex_bubble_o  output  1  select zero control word into ID/EX.
ex_mem_write_o  output  1  EX/MEM register load enable.
mem_wb_bubble_o  output  1  select zero control word into MEM/WB.
mem_busy_o  output  1  high while in state MEM_WAIT.
stall_cnt_o  output  CNT_W  count of cycles with pc_write_o=0 (saturating).
flush_cnt_o  output  CNT_W  count of cycles with if_id_flush_o=1 (saturating).

Behaviour:
- All control outputs are combinational from the state, wait counter and inputs, so they act in the same cycle.
- State, wait counter and performance counters are registered.
- States:
  - RUN: normal operation.
  - MEM_WAIT: holding for memory; wait counter wcnt is 4 bits wide.
- Reset (async, any state including mid-wait):
  - state=RUN, wcnt=0, both performance counters=0.
  - With inputs low, outputs are: pc_write=if_id_write=id_ex_write=ex_mem_write=1; if_id_flush=id_ex_bubble=mem_wb_bubble=mem_busy=0.
- Freeze pattern:
  - pc_write=if_id_write=id_ex_write=ex_mem_write=0, mem_wb_bubble=1.
  - if_id_flush=0, id_ex_bubble=0.
- RUN priority, highest first:
  1. dmem_req_i=1 and MEM_LAT>1: apply the freeze pattern; load wcnt=MEM_LAT-2; go to MEM_WAIT. load_use_i and branch_taken_i are ignored, because frozen stages re-present them later.
  2. load_use_i=1: pc_write=0, if_id_write=0, id_ex_bubble=1; all other controls normal; if_id_flush=0 even if branch_taken_i=1, since the branch re-evaluates after the bubble.
  3. branch_taken_i=1: if_id_flush=1, pc_write=1.
  4. Otherwise: all enables 1, no flush, no bubble.
- MEM_WAIT:
  - wcnt!=0: apply the freeze pattern; wcnt decrements.
  - wcnt=0 (release cycle): evaluate priorities 2-4 exactly as in RUN; dmem_req_i is ignored, so the same access cannot retrigger; go to RUN.
- Memory stall timing: exactly MEM_LAT-1 frozen cycles per access; the access completes in its MEM_LAT-th cycle.
- MEM_LAT=1: the block never leaves RUN and dmem_req_i has no effect.
- Back-to-back memory instructions: the next access triggers in the first RUN cycle after release.
- Performance counters: increment each cycle their condition holds; saturate at all ones; no wrap.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state enum {RUN, MEM_WAIT};
  - the freeze-pattern constant;
  - the CNT_W default.
- One sub-module, sat_counter (parameter W; ports clk_i, rst_i, inc_i, cnt_o), instantiated twice for stall_cnt_o and flush_cnt_o.

Test Plan:
- Reset mid-wait: MEM_LAT=3, dmem_req_i=1 then rst_i pulsed while mem_busy_o=1 -> state RUN, counters 0, pc_write_o=1 immediately.
- Load-use alone: load_use_i=1 for 1 cycle -> pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1 that cycle; stall_cnt_o=1 afterwards.
- Branch alone: branch_taken_i=1 for 1 cycle -> if_id_flush_o=1, pc_write_o=1; flush_cnt_o=1.
- Load-use and branch together: both inputs=1 -> id_ex_bubble_o=1, if_id_flush_o=0; flush_cnt_o stays 0.
- Memory stalls:
  - MEM_LAT=3, dmem_req_i held high for 3 cycles -> exactly 2 frozen cycles (mem_wb_bubble_o=1), release on the 3rd, stall_cnt_o=2.
  - Same stimulus with MEM_LAT=1 -> no freeze.
  - MEM_LAT=3, two consecutive memory instructions -> freeze 2, release, freeze 2, release; stall_cnt_o=4.
- Counter saturation: CNT_W=4, load_use_i held high 20 cycles -> stall_cnt_o stops at 15.
